// File: rtl/sa_pkg.sv
// Shared types and length helpers for the systolic-array tile scheduler.
package sa_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_FILL,
        S_CLEAR,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } sa_sched_state_t;

    function automatic int unsigned stream_len(input int unsigned k,
                                               input int unsigned rows,
                                               input int unsigned cols);
        return k + ((rows > cols) ? rows : cols) - 1;
    endfunction

    function automatic int unsigned drain_len(input int unsigned rows,
                                              input int unsigned cols);
        return rows + cols - 1;
    endfunction

endpackage

// File: rtl/sa_skew_window.sv
// Per-lane read-window decode: asserts while lo <= t < lo+K and the array advances.
module sa_skew_window #(
    parameter int unsigned LO  = 0,
    parameter int unsigned W_K = 8
) (
    input  logic [W_K:0]   i_t,
    input  logic [W_K-1:0] i_k,
    input  logic           i_adv,
    output logic           o_rden
);

    localparam logic [W_K+1:0] LO_EXT = (W_K+2)'(LO);

    logic [W_K+1:0] t_ext;
    logic [W_K+1:0] hi_ext;
    logic           lo_ok;

    always_comb begin
        t_ext  = {1'b0, i_t};
        hi_ext = LO_EXT + {2'b00, i_k};
    end

    // Lane 0 has no lower bound; avoid a constant unsigned compare.
    if (LO == 0) begin : g_lo_zero
        assign lo_ok = 1'b1;
    end else begin : g_lo_cmp
        assign lo_ok = (t_ext >= LO_EXT);
    end

    always_comb begin
        o_rden = i_adv && lo_ok && (t_ext < hi_ext);
    end

endmodule

// File: rtl/sa_tile_scheduler.sv
// Tile sequencer: waits for FIFO fill, clears accumulators, streams a skewed wavefront, drains.
module sa_tile_scheduler
    import sa_pkg::*;
#(
    parameter int unsigned ROW    = 9,
    parameter int unsigned COL    = 1,
    parameter int unsigned W_ADDR = 8,
    parameter int unsigned W_K    = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [W_K-1:0]    i_k_len,
    input  logic [W_ADDR:0]   i_row_level,
    input  logic [W_ADDR:0]   i_col_level,
    input  logic              i_out_full,
    output logic [ROW-1:0]    o_row_rden,
    output logic [COL-1:0]    o_col_rden,
    output logic              o_sa_enable,
    output logic              o_acc_clear,
    output logic              o_busy,
    output logic              o_done
);

    localparam int unsigned W_CMP = ((W_ADDR + 1) > W_K) ? (W_ADDR + 1) : W_K;
    localparam logic [W_K:0] DRAIN_LAST = (W_K+1)'(drain_len(ROW, COL) - 1);

    sa_sched_state_t state_q, state_d;
    logic [W_K:0]    t_q, t_d;
    logic [W_K-1:0]  k_q, k_d;

    logic             adv;
    logic             stream_adv;
    logic [W_K:0]     stream_last;
    logic [W_CMP-1:0] k_ext;
    logic [W_CMP-1:0] row_lvl_ext;
    logic [W_CMP-1:0] col_lvl_ext;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            t_q     <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            k_q     <= k_d;
        end
    end

    always_comb begin
        adv         = !i_out_full;
        stream_last = (W_K+1)'(stream_len(32'(k_q), ROW, COL) - 1);
        k_ext       = W_CMP'(k_q);
        row_lvl_ext = W_CMP'(i_row_level);
        col_lvl_ext = W_CMP'(i_col_level);

        state_d = state_q;
        t_d     = t_q;
        k_d     = k_q;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    if (i_k_len != '0) begin
                        k_d     = i_k_len;
                        state_d = S_WAIT_FILL;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_WAIT_FILL: begin
                if ((row_lvl_ext >= k_ext) && (col_lvl_ext >= k_ext)) begin
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                t_d     = '0;
                state_d = S_STREAM;
            end
            S_STREAM: begin
                if (adv) begin
                    if (t_q == stream_last) begin
                        t_d     = '0;
                        state_d = S_DRAIN;
                    end else begin
                        t_d = t_q + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (adv) begin
                    if (t_q == DRAIN_LAST) begin
                        t_d     = '0;
                        state_d = S_DONE;
                    end else begin
                        t_d = t_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        stream_adv  = (state_q == S_STREAM) && !i_out_full;
        o_sa_enable = ((state_q == S_STREAM) || (state_q == S_DRAIN)) && !i_out_full;
        o_acc_clear = (state_q == S_CLEAR);
        o_busy      = (state_q != S_IDLE);
        o_done      = (state_q == S_DONE);
    end

    for (genvar r = 0; r < ROW; r++) begin : g_row_win
        sa_skew_window #(
            .LO  (r),
            .W_K (W_K)
        ) u_row_win (
            .i_t    (t_q),
            .i_k    (k_q),
            .i_adv  (stream_adv),
            .o_rden (o_row_rden[r])
        );
    end

    for (genvar c = 0; c < COL; c++) begin : g_col_win
        sa_skew_window #(
            .LO  (c),
            .W_K (W_K)
        ) u_col_win (
            .i_t    (t_q),
            .i_k    (k_q),
            .i_adv  (stream_adv),
            .o_rden (o_col_rden[c])
        );
    end

endmodule

// File: tb/tb_sa_tile_scheduler.sv
// Randomized tile-scheduler bench; expected per-cycle outputs come from a trace built from the tile rules.
module tb_sa_tile_scheduler;

    localparam int unsigned ROW    = 3;
    localparam int unsigned COL    = 2;
    localparam int unsigned W_ADDR = 8;
    localparam int unsigned W_K    = 8;
    localparam int VW   = ROW + COL + 4;
    localparam int MAXC = 1024;

    logic              i_clk = 1'b0;
    logic              i_rst;
    logic              i_start;
    logic [W_K-1:0]    i_k_len;
    logic [W_ADDR:0]   i_row_level;
    logic [W_ADDR:0]   i_col_level;
    logic              i_out_full;
    logic [ROW-1:0]    o_row_rden;
    logic [COL-1:0]    o_col_rden;
    logic              o_sa_enable;
    logic              o_acc_clear;
    logic              o_busy;
    logic              o_done;

    int checks = 0;
    int errors = 0;

    logic [VW-1:0] e_vec [MAXC];
    bit            stall [MAXC];
    int            n_cyc;
    int            e_done_cyc;

    always #5 i_clk = ~i_clk;

    sa_tile_scheduler #(
        .ROW    (ROW),
        .COL    (COL),
        .W_ADDR (W_ADDR),
        .W_K    (W_K)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_start     (i_start),
        .i_k_len     (i_k_len),
        .i_row_level (i_row_level),
        .i_col_level (i_col_level),
        .i_out_full  (i_out_full),
        .o_row_rden  (o_row_rden),
        .o_col_rden  (o_col_rden),
        .o_sa_enable (o_sa_enable),
        .o_acc_clear (o_acc_clear),
        .o_busy      (o_busy),
        .o_done      (o_done)
    );

    function automatic logic [VW-1:0] obs();
        return {o_row_rden, o_col_rden, o_sa_enable, o_acc_clear, o_busy, o_done};
    endfunction

    function automatic logic [VW-1:0] mk(input logic [ROW-1:0] r, input logic [COL-1:0] cv,
                                         input logic en, input logic clr,
                                         input logic busy, input logic done);
        return {r, cv, en, clr, busy, done};
    endfunction

    // Expected trace: start at cycle 0, WAIT_FILL until levels suffice, one clear cycle,
    // K+max(ROW,COL)-1 stream beats and ROW+COL-1 drain beats, each beat pushed back by stalls.
    task automatic build_trace(input int k, input int lvl_cyc);
        int c;
        int m;
        logic [ROW-1:0] r;
        logic [COL-1:0] cv;
        m = (ROW > COL) ? ROW : COL;
        foreach (e_vec[i]) e_vec[i] = '0;
        if (k == 0) begin
            e_vec[1]   = mk('0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
            e_done_cyc = 1;
            n_cyc      = 3;
            return;
        end
        c = 1;
        forever begin
            e_vec[c] = mk('0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
            if (c >= lvl_cyc) break;
            c++;
        end
        c++;
        e_vec[c] = mk('0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
        c++;
        for (int b = 0; b < k + m - 1; b++) begin
            while (stall[c] && c < MAXC - 64) begin
                e_vec[c] = mk('0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
                c++;
            end
            for (int i = 0; i < ROW; i++) r[i] = (b >= i) && (b < i + k);
            for (int i = 0; i < COL; i++) cv[i] = (b >= i) && (b < i + k);
            e_vec[c] = mk(r, cv, 1'b1, 1'b0, 1'b1, 1'b0);
            c++;
        end
        for (int d = 0; d < ROW + COL - 1; d++) begin
            while (stall[c] && c < MAXC - 64) begin
                e_vec[c] = mk('0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
                c++;
            end
            e_vec[c] = mk('0, '0, 1'b1, 1'b0, 1'b1, 1'b0);
            c++;
        end
        e_vec[c]   = mk('0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
        e_done_cyc = c;
        n_cyc      = c + 2;
    endtask

    task automatic clear_stalls();
        foreach (stall[i]) stall[i] = 1'b0;
    endtask

    task automatic run_tile(input string name, input int k, input int lvl_cyc,
                            input bit spam, input int rst_cyc, input int exp_done);
        int rd_row [ROW];
        int rd_col [COL];
        int seen_done;
        int done_cnt;
        build_trace(k, lvl_cyc);
        foreach (rd_row[i]) rd_row[i] = 0;
        foreach (rd_col[i]) rd_col[i] = 0;
        seen_done = -1;
        done_cnt  = 0;
        for (int c = 0; c < n_cyc; c++) begin
            @(posedge i_clk);
            #1;
            i_start = (c == 0) || (spam && c <= e_done_cyc && $urandom_range(0, 1) == 1);
            i_k_len = (c == 0) ? W_K'(k) : W_K'($urandom_range(0, 20));
            if (k == 0 || c >= lvl_cyc) begin
                i_row_level = (W_ADDR+1)'(k + $urandom_range(0, 3));
                i_col_level = (W_ADDR+1)'(k + $urandom_range(0, 3));
            end else if ($urandom_range(0, 1) == 1) begin
                i_row_level = (W_ADDR+1)'(k - 1);
                i_col_level = (W_ADDR+1)'(k + $urandom_range(0, 3));
            end else begin
                i_row_level = (W_ADDR+1)'(k + $urandom_range(0, 3));
                i_col_level = (W_ADDR+1)'(k - 1);
            end
            i_out_full = stall[c];
            if (c == rst_cyc) begin
                i_rst = 1'b1;
                #1;
                checks++;
                if (obs() !== '0) begin
                    errors++;
                    $display("FAIL %s async_reset_outputs cyc %0d: got %b expected %b", name, c, obs(), {VW{1'b0}});
                end
                @(negedge i_clk);
                checks++;
                if (obs() !== '0) begin
                    errors++;
                    $display("FAIL %s reset_held_outputs cyc %0d: got %b expected %b", name, c, obs(), {VW{1'b0}});
                end
                @(posedge i_clk);
                #1;
                i_rst      = 1'b0;
                i_start    = 1'b0;
                i_out_full = 1'b0;
                repeat (4) begin
                    @(negedge i_clk);
                    checks++;
                    if ({o_busy, o_done} !== 2'b00) begin
                        errors++;
                        $display("FAIL %s post_reset_idle: got busy/done %b expected 00", name, {o_busy, o_done});
                    end
                end
                return;
            end
            @(negedge i_clk);
            checks++;
            if (obs() !== e_vec[c]) begin
                errors++;
                $display("FAIL %s outputs cyc %0d: got %b expected %b (row,col,en,clr,busy,done)", name, c, obs(), e_vec[c]);
            end
            for (int i = 0; i < ROW; i++) if (o_row_rden[i]) rd_row[i]++;
            for (int i = 0; i < COL; i++) if (o_col_rden[i]) rd_col[i]++;
            if (o_done) begin
                done_cnt++;
                if (seen_done < 0) seen_done = c;
            end
        end
        i_start    = 1'b0;
        i_out_full = 1'b0;
        for (int i = 0; i < ROW; i++) begin
            checks++;
            if (rd_row[i] !== k) begin
                errors++;
                $display("FAIL %s row_reads[%0d]: got %0d expected %0d", name, i, rd_row[i], k);
            end
        end
        for (int i = 0; i < COL; i++) begin
            checks++;
            if (rd_col[i] !== k) begin
                errors++;
                $display("FAIL %s col_reads[%0d]: got %0d expected %0d", name, i, rd_col[i], k);
            end
        end
        checks++;
        if (done_cnt !== 1) begin
            errors++;
            $display("FAIL %s done_count: got %0d expected 1", name, done_cnt);
        end
        if (exp_done >= 0) begin
            checks++;
            if (seen_done !== exp_done) begin
                errors++;
                $display("FAIL %s done_cycle: got %0d expected %0d", name, seen_done, exp_done);
            end
        end
    endtask

    task automatic test_reset();
        i_rst       = 1'b1;
        i_start     = 1'b0;
        i_k_len     = '0;
        i_row_level = '0;
        i_col_level = '0;
        i_out_full  = 1'b0;
        repeat (3) @(negedge i_clk);
        checks++;
        if (obs() !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected %b", obs(), {VW{1'b0}});
        end
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        @(negedge i_clk);
        checks++;
        if (obs() !== '0) begin
            errors++;
            $display("FAIL reset_release_idle: got %b expected %b", obs(), {VW{1'b0}});
        end
    endtask

    task automatic test_basic();
        clear_stalls();
        run_tile("basic_k4", 4, 1, 1'b0, -1, 13);
    endtask

    task automatic test_fill_wait();
        clear_stalls();
        run_tile("fill_wait", 4, 10, 1'b0, -1, 22);
    endtask

    task automatic test_stall();
        clear_stalls();
        for (int c = 5; c <= 7; c++) stall[c] = 1'b1;
        for (int c = 13; c <= 15; c++) stall[c] = 1'b1;
        run_tile("stall", 4, 1, 1'b0, -1, 19);
        clear_stalls();
    endtask

    task automatic test_k_zero();
        clear_stalls();
        run_tile("k_zero", 0, 1, 1'b0, -1, 1);
    endtask

    task automatic test_k_one();
        clear_stalls();
        run_tile("k_one", 1, 1, 1'b0, -1, 10);
    endtask

    task automatic test_restart_ignored();
        clear_stalls();
        run_tile("restart_ignored", 4, 1, 1'b1, -1, 13);
    endtask

    task automatic test_reset_mid_tile();
        clear_stalls();
        run_tile("reset_mid", 4, 1, 1'b0, 6, -1);
        run_tile("after_reset", 4, 1, 1'b0, -1, 13);
    endtask

    task automatic test_random();
        for (int n = 0; n < 20; n++) begin
            clear_stalls();
            for (int c = 0; c < 200; c++) stall[c] = ($urandom_range(0, 3) == 0);
            run_tile("random", int'($urandom_range(1, 12)), int'($urandom_range(1, 8)),
                     bit'($urandom_range(0, 1)), -1, -1);
        end
        clear_stalls();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_stalls();
        test_reset();
        test_basic();
        test_fill_wait();
        test_stall();
        test_k_zero();
        test_k_one();
        test_restart_ignored();
        test_reset_mid_tile();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
